// File: rtl/f32_hex_pkg.sv
// rtl/f32_hex_pkg.sv - shared states, ASCII constants and helpers for the float hex streamer
package f32_hex_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SIGN = 3'd1,
    EXPO = 3'd2,
    SEP  = 3'd3,
    MANT = 3'd4,
    FLAG = 3'd5
  } state_t;

  localparam logic [7:0] ASCII_NUL   = 8'h00;
  localparam logic [7:0] ASCII_PLUS  = 8'h2B;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_O     = 8'h4F;
  localparam logic [7:0] ASCII_U     = 8'h55;
  localparam logic [7:0] ASCII_COLON = 8'h3A;

  localparam int unsigned FRAME_LEN = 11;

  // Last digit index inside each multi-digit field (counter values)
  localparam logic [2:0] EXPO_LAST = 3'd1;
  localparam logic [2:0] MANT_LAST = 3'd5;

  function automatic logic [7:0] sign_char(input logic sign);
    return sign ? ASCII_MINUS : ASCII_PLUS;
  endfunction

  // Overflow wins over underflow when both are raised
  function automatic logic [7:0] flag_char(input logic ovf, input logic unf);
    if (ovf) return ASCII_O;
    if (unf) return ASCII_U;
    return ASCII_SPACE;
  endfunction

endpackage

// File: rtl/nibble_to_ascii.sv
// rtl/nibble_to_ascii.sv - combinational 4-bit to ASCII hex digit converter
module nibble_to_ascii #(
  parameter bit UPPERCASE = 1'b1
) (
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  // Offset so that base + 10 lands on 'A' (0x41) or 'a' (0x61)
  localparam logic [7:0] LETTER_BASE = UPPERCASE ? 8'h37 : 8'h57;

  // Digits 0-9 map to '0'-'9'; 10-15 map to the selected letter case
  always_comb begin
    ascii = 8'h30 + {4'h0, nibble};
    if (nibble > 4'd9) begin
      ascii = LETTER_BASE + {4'h0, nibble};
    end
  end

endmodule

// File: rtl/f32_hex_streamer.sv
// rtl/f32_hex_streamer.sv - streams an IEEE-754 single as "+EE:MMMMMMF" characters
module f32_hex_streamer
  import f32_hex_pkg::*;
#(
  parameter bit         UPPERCASE = 1'b1,
  parameter logic [7:0] SEPARATOR = 8'h3A
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic [31:0] VALUE,
  input  logic        OVERFLOW,
  input  logic        UNDERFLOW,
  output logic [7:0]  CHAR,
  output logic        CHAR_VALID,
  input  logic        CHAR_READY,
  output logic        BUSY,
  output logic        DONE
);

  state_t      state;
  logic [2:0]  digit_cnt;
  logic [31:0] value_q;
  logic        overflow_q;
  logic        underflow_q;

  logic        xfer;
  logic [23:0] mant_word;
  logic [3:0]  nib_sel;
  logic [7:0]  hex_char;

  assign xfer      = CHAR_VALID & CHAR_READY;
  assign mant_word = {1'b0, value_q[22:0]};

  // Pick the nibble of the character that follows the one currently offered
  always_comb begin
    nib_sel = 4'h0;
    case (state)
      SIGN: nib_sel = value_q[30:27];
      EXPO: nib_sel = value_q[26:23];
      SEP:  nib_sel = mant_word[23:20];
      MANT: begin
        case (digit_cnt)
          3'd0:    nib_sel = mant_word[19:16];
          3'd1:    nib_sel = mant_word[15:12];
          3'd2:    nib_sel = mant_word[11:8];
          3'd3:    nib_sel = mant_word[7:4];
          3'd4:    nib_sel = mant_word[3:0];
          default: nib_sel = 4'h0;
        endcase
      end
      default: nib_sel = 4'h0;
    endcase
  end

  nibble_to_ascii #(
    .UPPERCASE(UPPERCASE)
  ) u_hex (
    .nibble(nib_sel),
    .ascii (hex_char)
  );

  // Frame sequencer: CHAR is loaded one cycle ahead so every output stays registered
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= IDLE;
      digit_cnt   <= 3'd0;
      value_q     <= 32'h0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      CHAR        <= ASCII_NUL;
      CHAR_VALID  <= 1'b0;
      BUSY        <= 1'b0;
      DONE        <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            value_q     <= VALUE;
            overflow_q  <= OVERFLOW;
            underflow_q <= UNDERFLOW;
            CHAR        <= sign_char(VALUE[31]);
            CHAR_VALID  <= 1'b1;
            BUSY        <= 1'b1;
            digit_cnt   <= 3'd0;
            state       <= SIGN;
          end
        end
        SIGN: begin
          if (xfer) begin
            CHAR      <= hex_char;
            digit_cnt <= 3'd0;
            state     <= EXPO;
          end else begin
            // Refresh from the captured sign; the value is identical while stalled
            CHAR <= sign_char(value_q[31]);
          end
        end
        EXPO: begin
          if (xfer) begin
            if (digit_cnt == EXPO_LAST) begin
              CHAR      <= SEPARATOR;
              digit_cnt <= 3'd0;
              state     <= SEP;
            end else begin
              CHAR      <= hex_char;
              digit_cnt <= digit_cnt + 3'd1;
            end
          end
        end
        SEP: begin
          if (xfer) begin
            CHAR      <= hex_char;
            digit_cnt <= 3'd0;
            state     <= MANT;
          end
        end
        MANT: begin
          if (xfer) begin
            if (digit_cnt == MANT_LAST) begin
              CHAR      <= flag_char(overflow_q, underflow_q);
              digit_cnt <= 3'd0;
              state     <= FLAG;
            end else begin
              CHAR      <= hex_char;
              digit_cnt <= digit_cnt + 3'd1;
            end
          end
        end
        FLAG: begin
          if (xfer) begin
            CHAR       <= ASCII_NUL;
            CHAR_VALID <= 1'b0;
            BUSY       <= 1'b0;
            DONE       <= 1'b1;
            digit_cnt  <= 3'd0;
            state      <= IDLE;
          end
        end
        default: begin
          CHAR_VALID <= 1'b0;
          BUSY       <= 1'b0;
          digit_cnt  <= 3'd0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_f32_hex_streamer.sv
// tb/tb_f32_hex_streamer.sv - scoreboard bench for the float hex streamer
module tb_f32_hex_streamer;
  import f32_hex_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        START;
  logic        START_LC;
  logic [31:0] VALUE;
  logic        OVERFLOW;
  logic        UNDERFLOW;
  logic        CHAR_READY;
  logic [7:0]  CHAR,       CHAR_LC;
  logic        CHAR_VALID, CHAR_VALID_LC;
  logic        BUSY,       BUSY_LC;
  logic        DONE,       DONE_LC;

  int tests = 0;
  int fails = 0;

  logic [7:0] exp_uc[$];
  logic [7:0] exp_lc[$];

  // 100 MHz clock
  always #5 CLK = ~CLK;

  f32_hex_streamer #(.UPPERCASE(1'b1), .SEPARATOR(8'h3A)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .VALUE(VALUE),
    .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW),
    .CHAR(CHAR), .CHAR_VALID(CHAR_VALID), .CHAR_READY(CHAR_READY),
    .BUSY(BUSY), .DONE(DONE)
  );

  f32_hex_streamer #(.UPPERCASE(1'b0), .SEPARATOR(8'h3A)) dut_lc (
    .CLK(CLK), .RESET(RESET), .START(START_LC), .VALUE(VALUE),
    .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW),
    .CHAR(CHAR_LC), .CHAR_VALID(CHAR_VALID_LC), .CHAR_READY(CHAR_READY),
    .BUSY(BUSY_LC), .DONE(DONE_LC)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input string s, input bit lc);
    for (int i = 0; i < s.len(); i++) begin
      if (lc) exp_lc.push_back(s[i]);
      else    exp_uc.push_back(s[i]);
    end
  endtask

  task automatic pulse_start(input logic [31:0] v, input logic ov, input logic un, input bit lc_too);
    VALUE     = v;
    OVERFLOW  = ov;
    UNDERFLOW = un;
    START     = 1'b1;
    START_LC  = lc_too;
    step();
    START     = 1'b0;
    START_LC  = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (DONE !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    check(name, {31'h0, DONE}, 32'h1);
  endtask

  // Monitor for the uppercase instance: pops on every transfer, checks stall stability
  initial begin
    logic [7:0] held = 8'h00;
    bit stalled = 1'b0;
    forever begin
      @(negedge CLK);
      if (!RESET && CHAR_VALID && CHAR_READY) begin
        if (exp_uc.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL uc_unexpected: got %0h expected none", CHAR);
        end else begin
          check("uc_stream", {24'h0, CHAR}, {24'h0, exp_uc.pop_front()});
        end
      end
      if (!RESET && CHAR_VALID && !CHAR_READY) begin
        if (stalled) check("uc_hold", {24'h0, CHAR}, {24'h0, held});
        held    = CHAR;
        stalled = 1'b1;
      end else begin
        stalled = 1'b0;
      end
    end
  end

  // Monitor for the lowercase instance
  initial begin
    forever begin
      @(negedge CLK);
      if (!RESET && CHAR_VALID_LC && CHAR_READY) begin
        if (exp_lc.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL lc_unexpected: got %0h expected none", CHAR_LC);
        end else begin
          check("lc_stream", {24'h0, CHAR_LC}, {24'h0, exp_lc.pop_front()});
        end
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET      = 1'b1;
    START      = 1'b0;
    START_LC   = 1'b0;
    VALUE      = 32'h0;
    OVERFLOW   = 1'b0;
    UNDERFLOW  = 1'b0;
    CHAR_READY = 1'b1;
    step();
    step();
    check("rst_char",  {24'h0, CHAR}, 32'h0);
    check("rst_valid", {31'h0, CHAR_VALID}, 32'h0);
    check("rst_busy",  {31'h0, BUSY}, 32'h0);
    check("rst_done",  {31'h0, DONE}, 32'h0);
    check("rst_lc_valid", {31'h0, CHAR_VALID_LC}, 32'h0);
    RESET = 1'b0;
    step();

    // One frame at full rate: 11 consecutive characters, DONE on the 12th cycle
    push("+7F:000000 ", 1'b0);
    pulse_start(32'h3F800000, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < FRAME_LEN; i++) begin
      check("full_rate_valid", {31'h0, CHAR_VALID}, 32'h1);
      check("full_rate_busy",  {31'h0, BUSY}, 32'h1);
      step();
    end
    check("frame_done",     {31'h0, DONE}, 32'h1);
    check("frame_busy_low", {31'h0, BUSY}, 32'h0);
    check("frame_valid_low", {31'h0, CHAR_VALID}, 32'h0);
    step();
    check("done_one_shot", {31'h0, DONE}, 32'h0);

    // Both flags set, upper and lower case letters
    push("-80:490FDBO", 1'b0);
    push("-80:490fdbO", 1'b1);
    pulse_start(32'hC0490FDB, 1'b1, 1'b1, 1'b1);
    wait_done("pi_done");
    check("pi_lc_done", {31'h0, DONE_LC}, 32'h1);
    step();

    // Underflow only, and overflow with all-F mantissa
    push("+00:000001U", 1'b0);
    pulse_start(32'h00000001, 1'b0, 1'b1, 1'b0);
    wait_done("unf_done");
    step();
    push("+FE:7FFFFFO", 1'b0);
    pulse_start(32'h7F7FFFFF, 1'b1, 1'b0, 1'b0);
    wait_done("ovf_done");
    step();

    // Back-pressure while the separator is offered
    push("+7F:000000 ", 1'b0);
    pulse_start(32'h3F800000, 1'b0, 1'b0, 1'b0);
    step();
    step();
    step();
    CHAR_READY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("stall_sep",   {24'h0, CHAR}, 32'h3A);
      check("stall_valid", {31'h0, CHAR_VALID}, 32'h1);
      step();
    end
    CHAR_READY = 1'b1;
    wait_done("stall_done");
    step();

    // Reset while the sixth character is offered
    push("+7F:0", 1'b0);
    pulse_start(32'h3F800000, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step();
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    check("abort_valid", {31'h0, CHAR_VALID}, 32'h0);
    check("abort_busy",  {31'h0, BUSY}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      check("abort_no_done", {31'h0, DONE}, 32'h0);
      step();
    end
    check("abort_queue_empty", exp_uc.size(), 32'h0);
    push("+24:345678 ", 1'b0);
    pulse_start(32'h12345678, 1'b0, 1'b0, 1'b0);
    wait_done("after_abort_done");
    step();

    // START while busy is ignored; START in the DONE cycle is taken
    push("+7F:000000 ", 1'b0);
    pulse_start(32'h3F800000, 1'b0, 1'b0, 1'b0);
    step();
    VALUE    = 32'hC0490FDB;
    OVERFLOW = 1'b1;
    START    = 1'b1;
    step();
    START = 1'b0;
    check("busy_start_ignored", {31'h0, BUSY}, 32'h1);
    wait_done("busy_frame_done");
    push("-7F:000000 ", 1'b0);
    VALUE    = 32'hBF800000;
    OVERFLOW = 1'b0;
    START    = 1'b1;
    step();
    START = 1'b0;
    check("done_cycle_start_valid", {31'h0, CHAR_VALID}, 32'h1);
    check("done_cycle_start_char",  {24'h0, CHAR}, 32'h2D);
    check("done_cycle_start_busy",  {31'h0, BUSY}, 32'h1);
    wait_done("back_to_back_done");
    step();
    step();

    check("uc_queue_drained", exp_uc.size(), 32'h0);
    check("lc_queue_drained", exp_lc.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/f32_hex_streamer.md
F32_HEX_STREAMER -- requirements
Module: f32_hex_streamer

Interface
REQ-001 SHALL have parameter UPPERCASE, default 1: hex letters A-F as 0x41-0x46 when 1, a-f as 0x61-0x66 when 0.
REQ-002 SHALL have parameter SEPARATOR, default 8'h3A (':'): character emitted between exponent and mantissa fields.
REQ-003 SHALL have port CLK  input  1  single system clock; all logic on posedge CLK.
REQ-004 SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-005 SHALL have port START  input  1  request to stream VALUE; sampled only in IDLE.
REQ-006 SHALL have port VALUE  input  32  IEEE-754 single; bit 31 sign, 30:23 exponent, 22:0 mantissa.
REQ-007 SHALL have port OVERFLOW  input  1  arithmetic overflow flag, captured with VALUE.
REQ-008 SHALL have port UNDERFLOW  input  1  arithmetic underflow flag, captured with VALUE.
REQ-009 SHALL have port CHAR  output  8  ASCII character being offered.
REQ-010 SHALL have port CHAR_VALID  output  1  CHAR holds a valid character.
REQ-011 SHALL have port CHAR_READY  input  1  sink accepts CHAR this cycle.
REQ-012 SHALL have port BUSY  output  1  high from capture until final transfer completes.
REQ-013 SHALL have port DONE  output  1  one-cycle pulse after final character transferred.

Function
REQ-014 SHALL emit exactly 11 characters per frame, in order: sign, 2 exponent hex digits (MSB first), SEPARATOR, 6 mantissa hex digits of {1'b0,VALUE[22:0]} (MSB first), flag.
REQ-015 Sign character SHALL be '+' (0x2B) for bit 31 = 0, '-' (0x2D) for 1.
REQ-016 Flag character SHALL be 'O' (0x4F) if OVERFLOW, else 'U' (0x55) if UNDERFLOW, else space (0x20); OVERFLOW has priority.
REQ-017 Nibble 0-9 SHALL map to 0x30-0x39; 10-15 per UPPERCASE.
REQ-018 FSM states SHALL be IDLE, SIGN, EXPO, SEP, MANT, FLAG; IDLE->SIGN on START; SIGN->EXPO, EXPO->SEP after 2nd digit, SEP->MANT, MANT->FLAG after 6th digit, FLAG->IDLE, each on a transfer.
REQ-019 In IDLE with START=1, SHALL register VALUE, OVERFLOW, UNDERFLOW; CHAR_VALID and BUSY SHALL be 1 from the next cycle.
REQ-020 A transfer SHALL occur on a posedge where CHAR_VALID=1 and CHAR_READY=1; the next character SHALL be presented the following cycle with no bubble.
REQ-021 While CHAR_VALID=1 and CHAR_READY=0, CHAR SHALL remain stable and CHAR_VALID SHALL stay 1.
REQ-022 CHAR_VALID SHALL never depend combinationally on CHAR_READY.
REQ-023 After the flag transfer, the next cycle SHALL have DONE=1, BUSY=0, CHAR_VALID=0, state IDLE; START in that cycle SHALL be accepted.
REQ-024 START while BUSY=1 SHALL be ignored; changes on VALUE/flags after capture SHALL not affect the frame.
REQ-025 Digit counter SHALL be 3 bits, cleared on each field entry; no wrap beyond field length.
REQ-026 With CHAR_READY held 1, frame SHALL occupy 11 consecutive cycles, DONE on the 12th after capture.

Reset
REQ-027 RESET SHALL force state IDLE, CHAR=0x00, CHAR_VALID=0, BUSY=0, DONE=0, counter=0, captured registers=0.
REQ-028 RESET mid-frame SHALL abort the frame with no further characters and no DONE pulse; RESET has priority over START and transfers in the same cycle.

Structure
REQ-029 Package f32_hex_pkg SHALL hold the state enum, ASCII constants ('+', '-', ' ', 'O', 'U', ':') and frame length 11.
REQ-030 Sub-module nibble_to_ascii (4-bit in, 8-bit out, UPPERCASE parameter, combinational) SHALL perform REQ-017.

Verification
REQ-031 VALUE=0x3F800000, flags 0, READY=1 -> "+7F:000000 " on 11 consecutive cycles, DONE on 12th.
REQ-032 VALUE=0xC0490FDB, OVERFLOW=1, UNDERFLOW=1 -> "-80:490FDBO"; UPPERCASE=0 -> "-80:490fdbO".
REQ-033 READY low 3 cycles while 4th char (':') offered -> ':' held 3 cycles, stream resumes "000000 " without loss/duplication.
REQ-034 RESET asserted 1 cycle during 6th char -> next cycle CHAR_VALID=0, BUSY=0, no DONE; new START yields full frame.
REQ-035 START pulsed with new VALUE while BUSY -> ignored, original frame unchanged; START in DONE cycle -> new frame begins next cycle.
